// File: rtl/mnist_lut_net_arbiter.sv
// mnist_lut_net_arbiter
//
// Shares one pipelined LUT-network instance between NUM_REQ image sources.
// Requesters are granted round-robin. Each issued image is tagged with the
// requester id in the upper user bits. Each network result is parked in a
// single-entry result register and steered back to the requester that
// issued it. The whole network is stalled through net_cke while the
// addressed consumer is not ready.
//
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   enable           : allow new grants (0 lets the pipeline drain)
//   busy             : images in flight or result register occupied
//   s_req_*          : per-requester user/data/valid in, one-hot ready out
//   net_cke          : network clock enable
//   net_in_*         : image issued to the network, user = {id, user}
//   net_out_*        : result returned by the network, user = {id, user}
//   m_res_*          : result user/data, one-hot valid, per-requester ready
module mnist_lut_net_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ID_WIDTH     = 2,
  parameter int USER_WIDTH   = 8,
  parameter int INPUT_WIDTH  = 784,
  parameter int OUTPUT_WIDTH = 10,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             enable,
  output logic                             busy,
  input  logic [NUM_REQ*USER_WIDTH-1:0]    s_req_user,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0]   s_req_data,
  input  logic [NUM_REQ-1:0]               s_req_valid,
  output logic [NUM_REQ-1:0]               s_req_ready,
  output logic                             net_cke,
  output logic [ID_WIDTH+USER_WIDTH-1:0]   net_in_user,
  output logic [INPUT_WIDTH-1:0]           net_in_data,
  output logic                             net_in_valid,
  input  logic [ID_WIDTH+USER_WIDTH-1:0]   net_out_user,
  input  logic [OUTPUT_WIDTH-1:0]          net_out_data,
  input  logic                             net_out_valid,
  output logic [USER_WIDTH-1:0]            m_res_user,
  output logic [OUTPUT_WIDTH-1:0]          m_res_data,
  output logic [NUM_REQ-1:0]               m_res_valid,
  input  logic [NUM_REQ-1:0]               m_res_ready
);

  logic                    full_q, full_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [USER_WIDTH-1:0]   user_q, user_d;
  logic [OUTPUT_WIDTH-1:0] data_q, data_d;
  logic [ID_WIDTH-1:0]     rr_q, rr_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic                    res_ready_sel;
  logic                    pop;
  logic                    cap;
  logic                    issue;
  logic [NUM_REQ-1:0]      upper_valid;
  logic [NUM_REQ-1:0]      cand;
  logic [ID_WIDTH-1:0]     gnt_id;
  logic [USER_WIDTH-1:0]   user_sel;

  // Ready of the held entry's consumer. An id with no matching requester
  // keeps the default of 1, so such an entry is dropped on the next cycle
  // and never raises m_res_valid.
  always_comb begin
    res_ready_sel = 1'b1;
    m_res_valid   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (id_q == ID_WIDTH'(i)) begin
        res_ready_sel  = m_res_ready[i];
        m_res_valid[i] = full_q;
      end
    end
    pop     = full_q & res_ready_sel;
    net_cke = ~reset_n | ~full_q | res_ready_sel;
    cap     = net_cke & net_out_valid;
  end

  // Round-robin search. Requesters at or above the pointer take priority.
  // If none of them is valid, the search wraps to the lowest valid index.
  // Issue is blocked during a stall, so nothing is accepted that the
  // frozen network could lose.
  always_comb begin
    upper_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper_valid[i] = s_req_valid[i] & (ID_WIDTH'(i) >= rr_q);
    end
    cand   = (|upper_valid) ? upper_valid : s_req_valid;
    gnt_id = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) gnt_id = ID_WIDTH'(i);
    end
    issue = reset_n & enable & net_cke & ~(&cnt_q) & (|s_req_valid);

    s_req_ready = '0;
    net_in_data = '0;
    user_sel    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (issue && (gnt_id == ID_WIDTH'(i))) begin
        s_req_ready[i] = 1'b1;
        net_in_data    = s_req_data[i*INPUT_WIDTH +: INPUT_WIDTH];
        user_sel       = s_req_user[i*USER_WIDTH +: USER_WIDTH];
      end
    end
    net_in_valid = issue;
    net_in_user  = issue ? {gnt_id, user_sel} : '0;
  end

  // Next-state logic for the pointer, the in-flight counter and the result
  // register. Issue and capture can only happen with net_cke high, so the
  // counter is implicitly frozen during a stall.
  always_comb begin
    rr_d = rr_q;
    if (issue) begin
      rr_d = (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + ID_WIDTH'(1);
    end

    cnt_d = cnt_q;
    if (issue && !cap) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (cap && !issue && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end

    full_d = full_q;
    id_d   = id_q;
    user_d = user_q;
    data_d = data_q;
    if (cap) begin
      full_d = 1'b1;
      id_d   = net_out_user[ID_WIDTH+USER_WIDTH-1:USER_WIDTH];
      user_d = net_out_user[USER_WIDTH-1:0];
      data_d = net_out_data;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      id_q   <= '0;
      user_q <= '0;
      data_q <= '0;
      rr_q   <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      id_q   <= id_d;
      user_q <= user_d;
      data_q <= data_d;
      rr_q   <= rr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign m_res_user = user_q;
  assign m_res_data = data_q;
  assign busy       = (cnt_q != '0) | full_q;

endmodule

// File: tb/tb_mnist_lut_net_arbiter.sv
// Testbench for mnist_lut_net_arbiter.
// The network is modelled as a 3-stage delay line gated by net_cke. Its
// result data is the low nibble of the returned user field. The bench
// keeps its own model of arbitration and of the held result. Expected
// results are queued at issue time and popped by a separate monitor.
module tb_mnist_lut_net_arbiter;

  localparam int NR     = 4;
  localparam int IW     = 3;
  localparam int UW     = 8;
  localparam int DW     = 784;
  localparam int OW     = 10;
  localparam int CW     = 8;
  localparam int TW     = IW + UW;
  localparam int BAD_ID = 5;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [UW-1:0] user;
    logic [OW-1:0] data;
  } res_t;

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic              busy;
  logic [NR*UW-1:0]  s_req_user;
  logic [NR*DW-1:0]  s_req_data;
  logic [NR-1:0]     s_req_valid;
  logic [NR-1:0]     s_req_ready;
  logic              net_cke;
  logic [TW-1:0]     net_in_user;
  logic [DW-1:0]     net_in_data;
  logic              net_in_valid;
  logic [TW-1:0]     net_out_user;
  logic [OW-1:0]     net_out_data;
  logic              net_out_valid;
  logic [UW-1:0]     m_res_user;
  logic [OW-1:0]     m_res_data;
  logic [NR-1:0]     m_res_valid;
  logic [NR-1:0]     m_res_ready;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Network delay line and model of the arbiter-visible state.
  logic          st_v[3];
  logic [TW-1:0] st_tag[3];
  bit            hold;
  int            hold_id;
  int            m_rr;
  int            dut_gcount[NR];
  int            delivered;
  int            stall_cnt;
  int            d0;
  logic [UW-1:0] usr[NR];
  logic [DW-1:0] img[NR];
  res_t          exp_q[$];

  mnist_lut_net_arbiter #(
    .NUM_REQ(NR), .ID_WIDTH(IW), .USER_WIDTH(UW),
    .INPUT_WIDTH(DW), .OUTPUT_WIDTH(OW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .busy(busy),
    .s_req_user(s_req_user), .s_req_data(s_req_data),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .net_cke(net_cke), .net_in_user(net_in_user), .net_in_data(net_in_data),
    .net_in_valid(net_in_valid), .net_out_user(net_out_user),
    .net_out_data(net_out_data), .net_out_valid(net_out_valid),
    .m_res_user(m_res_user), .m_res_data(m_res_data),
    .m_res_valid(m_res_valid), .m_res_ready(m_res_ready)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic checkData(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic driveNet();
    net_out_valid = st_v[2];
    net_out_user  = st_tag[2];
    net_out_data  = OW'(st_tag[2][3:0]);
  endtask

  // One clock cycle: drive inputs, check the combinational and registered
  // outputs against the model, then advance the model past the coming edge.
  task automatic applyStimulus(input logic [NR-1:0] v, input logic en,
                               input logic [NR-1:0] rdy, input bit inj,
                               input int fixed_user);
    bit            cke_exp, found, pop, cap;
    int            g;
    logic [NR-1:0] exp_rdy, exp_mv;
    logic [TW-1:0] tag;
    res_t          r;
    @(negedge clk);
    driveNet();
    for (int i = 0; i < NR; i++) begin
      usr[i] = (fixed_user >= 0) ? UW'(fixed_user) : UW'($urandom);
      for (int w = 0; w < DW / 16; w++) img[i][w*16 +: 16] = 16'($urandom);
      s_req_user[i*UW +: UW] = usr[i];
      s_req_data[i*DW +: DW] = img[i];
    end
    s_req_valid = v;
    enable      = en;
    m_res_ready = rdy;
    #1;
    cke_exp = !hold || (hold_id >= NR) || rdy[hold_id];
    found = 1'b0;
    g = 0;
    if (en && cke_exp) begin
      for (int k = 0; k < NR; k++) begin
        if (!found && v[(m_rr + k) % NR]) begin
          found = 1'b1;
          g = (m_rr + k) % NR;
        end
      end
    end
    exp_rdy = found ? (NR'(1) << g) : '0;
    exp_mv  = (hold && hold_id < NR) ? (NR'(1) << hold_id) : '0;
    tag     = found ? {IW'(g), usr[g]} : '0;
    checkOutput("net_cke", net_cke, cke_exp);
    checkOutput("s_req_ready", s_req_ready, exp_rdy);
    checkOutput("net_in_valid", net_in_valid, found);
    checkOutput("net_in_user", net_in_user, tag);
    checkData("net_in_data", net_in_data, found ? img[g] : '0);
    checkOutput("m_res_valid", m_res_valid, exp_mv);
    checkOutput("busy", busy, hold || st_v[0] || st_v[1] || st_v[2]);
    if (net_cke === 1'b0) stall_cnt++;
    for (int i = 0; i < NR; i++) if (s_req_ready[i] && v[i]) dut_gcount[i]++;

    pop = hold && ((hold_id >= NR) || rdy[hold_id]);
    cap = cke_exp && st_v[2];
    if (cap) begin
      hold    = 1'b1;
      hold_id = int'(st_tag[2][TW-1:UW]);
    end else if (pop) begin
      hold = 1'b0;
    end
    if (cke_exp) begin
      st_v[2]   = st_v[1];   st_tag[2] = st_tag[1];
      st_v[1]   = st_v[0];   st_tag[1] = st_tag[0];
      st_v[0]   = found;
      st_tag[0] = (inj && found) ? {IW'(BAD_ID), usr[g]} : tag;
    end
    if (found) begin
      m_rr = (g + 1) % NR;
      if (!inj) begin
        r.id   = IW'(g);
        r.user = usr[g];
        r.data = OW'(usr[g][3:0]);
        exp_q.push_back(r);
      end
    end
  endtask

  // Assert reset with requests pending; outputs must take reset values at
  // once. The network model is flushed too, as a real network would be.
  task automatic doReset(input int cycles);
    @(negedge clk);
    reset_n     = 1'b0;
    s_req_valid = '1;
    enable      = 1'b1;
    m_res_ready = '1;
    for (int i = 0; i < 3; i++) begin
      st_v[i]   = 1'b0;
      st_tag[i] = '0;
    end
    hold = 1'b0;
    hold_id = 0;
    m_rr = 0;
    exp_q.delete();
    driveNet();
    #1;
    checkOutput("rst_net_cke", net_cke, 1);
    checkOutput("rst_s_req_ready", s_req_ready, 0);
    checkOutput("rst_net_in_valid", net_in_valid, 0);
    checkOutput("rst_net_in_user", net_in_user, 0);
    checkOutput("rst_m_res_valid", m_res_valid, 0);
    checkOutput("rst_m_res_user", m_res_user, 0);
    checkOutput("rst_m_res_data", m_res_data, 0);
    checkOutput("rst_busy", busy, 0);
    repeat (cycles) @(negedge clk);
    s_req_valid = '0;
    enable      = 1'b0;
    reset_n     = 1'b1;
  endtask

  // Result monitor: whenever the DUT presents a result, compare it with the
  // oldest expected result and retire it once the consumer accepts it.
  initial begin
    res_t          f;
    logic [NR-1:0] oh;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n === 1'b1 && m_res_valid !== '0) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          bad_cnt++;
          $display("[TB] FAIL unexpected_result got m_res_valid=%0h exp=0", m_res_valid);
        end else begin
          f  = exp_q[0];
          oh = NR'(1) << f.id;
          checkOutput("result", {m_res_valid, m_res_user, m_res_data}, {oh, f.user, f.data});
          if ((m_res_valid & m_res_ready) != '0) begin
            void'(exp_q.pop_front());
            delivered++;
          end
        end
      end
    end
  end

  // Test sequence.
  initial begin
    reset_n = 1'b0; enable = 1'b0; s_req_valid = '0; s_req_user = '0;
    s_req_data = '0; m_res_ready = '1;
    net_out_valid = 1'b0; net_out_user = '0; net_out_data = '0;
    hold = 1'b0; hold_id = 0; m_rr = 0; delivered = 0; stall_cnt = 0;
    for (int i = 0; i < 3; i++) begin st_v[i] = 1'b0; st_tag[i] = '0; end
    for (int i = 0; i < NR; i++) dut_gcount[i] = 0;

    doReset(2);
    $display("[TB] fairness");
    repeat (100) applyStimulus('1, 1'b1, '1, 1'b0, -1);
    for (int i = 0; i < NR; i++)
      checkOutput($sformatf("fair_count%0d", i), 64'(dut_gcount[i]), 25);
    repeat (8) applyStimulus('0, 1'b1, '1, 1'b0, -1);

    $display("[TB] single source");
    d0 = delivered;
    applyStimulus(4'b0100, 1'b1, '1, 1'b0, 8'h15);
    repeat (6) applyStimulus('0, 1'b1, '1, 1'b0, -1);
    checkOutput("single_delivered", 64'(delivered - d0), 1);

    $display("[TB] backpressure");
    stall_cnt = 0;
    repeat (12) applyStimulus('1, 1'b1, 4'b1101, 1'b0, -1);
    repeat (12) applyStimulus('0, 1'b1, '1, 1'b0, -1);
    checkOutput("stall_seen", 64'(stall_cnt >= 5), 1);
    checkOutput("bp_queue_empty", 64'(exp_q.size()), 0);

    $display("[TB] drain");
    d0 = delivered;
    repeat (6) applyStimulus('1, 1'b1, '1, 1'b0, -1);
    repeat (10) applyStimulus('1, 1'b0, '1, 1'b0, -1);
    checkOutput("drain_delivered", 64'(delivered - d0), 6);
    checkOutput("drain_busy", busy, 0);

    $display("[TB] reset mid-operation");
    repeat (3) applyStimulus('1, 1'b1, '1, 1'b0, -1);
    doReset(2);
    applyStimulus('1, 1'b1, '1, 1'b0, -1);
    checkOutput("post_reset_grant", s_req_ready, 4'b0001);
    repeat (8) applyStimulus('0, 1'b1, '1, 1'b0, -1);

    $display("[TB] bad id");
    d0 = delivered;
    applyStimulus(4'b0001, 1'b1, '1, 1'b1, -1);
    applyStimulus(4'b0010, 1'b1, '1, 1'b0, -1);
    repeat (8) applyStimulus('0, 1'b1, '1, 1'b0, -1);
    checkOutput("badid_delivered", 64'(delivered - d0), 1);

    $display("[TB] random");
    repeat (400)
      applyStimulus(NR'($urandom), $urandom_range(0, 7) != 0,
                    NR'($urandom) | NR'($urandom), $urandom_range(0, 15) == 0, -1);
    repeat (15) applyStimulus('0, 1'b0, '1, 1'b0, -1);
    checkOutput("final_queue_empty", 64'(exp_q.size()), 0);
    checkOutput("final_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
